// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: serial word receiver for the host-to-MAC command path.
// Syncs sclk/sdata/sel_n into clk, shifts LSB first, hands words out by valid/ready.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   sclk_in          async serial bit clock, data sampled on its rise
//   sdata_in         async serial data, LSB first
//   sel_n_in         async frame select, active low
//   word_out         last completed word (stable while word_valid)
//   word_valid       word_out holds an unconsumed word
//   word_ready       downstream accepts word_out with word_valid
//   busy             high while a frame is being shifted
//   overrun          sticky: word completed while previous unconsumed
//   frame_err        sticky: frame ended with a partial word
//   err_clr          clears overrun and frame_err
//
// Parameters: WIDTH in 2..64, and 2**CNT_W must exceed WIDTH.

module sipo_rx_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic             sdata_in,
  input  logic             sel_n_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic sclk_s1;
  logic sclk_s2;
  logic sclk_s3;
  logic sdata_s1;
  logic sdata_s2;
  logic sel_n_s1;
  logic sel_n_s2;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] sr;

  logic             rise;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;
  logic             in_shift;
  logic             shift_en;
  logic             word_done;
  logic             accept;
  logic             ovr_evt;
  logic             fe_evt;

  // Sync chains reset to the levels an idle host drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
      sel_n_s1 <= 1'b1;
      sel_n_s2 <= 1'b1;
    end else begin
      sclk_s1  <= sclk_in;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      sdata_s1 <= sdata_in;
      sdata_s2 <= sdata_s1;
      sel_n_s1 <= sel_n_in;
      sel_n_s2 <= sel_n_s1;
    end
  end

  assign rise     = sclk_s2 & ~sclk_s3;
  assign sr_next  = {sdata_s2, sr[WIDTH-1:1]};
  assign last_bit = (bit_cnt == LAST_CNT);
  assign in_shift = (state == SHIFT);

  // A frame-select exit beats a rise in the same cycle.
  assign shift_en  = in_shift & ~sel_n_s2 & rise;
  assign word_done = shift_en & last_bit;

  assign accept  = ~word_valid | word_ready;
  assign ovr_evt = word_done & ~accept;
  assign fe_evt  = in_shift & sel_n_s2 & (bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!sel_n_s2) begin
            state <= SHIFT;
            sr    <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (sel_n_s2) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
          end else if (rise) begin
            sr <= sr_next;
            if (last_bit) begin
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Output word register; a completion and a consume in the
  // same cycle replace the word and keep valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (word_done) begin
      if (accept) begin
        word_out   <= sr_next;
        word_valid <= 1'b1;
      end
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Sticky flags; a fresh event outranks err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun & ~err_clr) | ovr_evt;
      frame_err <= (frame_err & ~err_clr) | fe_evt;
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb_sipo_rx_ctrl: directed plus random frames against a
// cycle-level behavioural model, with literal spot checks.

module tb_sipo_rx_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk_in;
  logic         sdata_in;
  logic         sel_n_in;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         busy;
  logic         overrun;
  logic         frame_err;
  logic         err_clr;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_on  = 1'b0;

  sipo_rx_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk_in    (sclk_in),
    .sdata_in   (sdata_in),
    .sel_n_in   (sel_n_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // Model: inputs seen by the logic are the pins delayed two
  // cycles; a bit arrives when delayed sclk goes 0 -> 1.
  bit         sh [1:3];
  bit         dh [1:2];
  bit         nh [1:2];
  bit         m_frame;
  int         m_n;
  bit [W-1:0] m_acc;
  bit [W-1:0] m_out;
  bit         m_valid;
  bit         m_ovr;
  bit         m_fe;
  bit         m_init = 1'b0;

  always @(posedge clk) begin
    bit rs;
    bit done;
    bit e_ovr;
    bit e_fe;
    if (reset) begin
      sh = '{0, 0, 0};
      dh = '{0, 0};
      nh = '{1, 1};
      m_frame = 0; m_n = 0; m_acc = '0;
      m_out = '0; m_valid = 0;
      m_ovr = 0; m_fe = 0;
      m_init = 1'b1;
    end else begin
      rs = sh[2] && !sh[3];
      done = 0; e_ovr = 0; e_fe = 0;
      if (!m_frame) begin
        if (!nh[2]) begin
          m_frame = 1; m_n = 0; m_acc = '0;
        end
      end else if (nh[2]) begin
        m_frame = 0;
        e_fe = (m_n != 0);
        m_n = 0;
      end else if (rs) begin
        m_acc[m_n] = dh[2];
        m_n = m_n + 1;
        if (m_n == W) begin
          done = 1;
          m_n = 0;
        end
      end
      if (done) begin
        if (!m_valid || word_ready) begin
          m_out = m_acc;
          m_valid = 1;
        end else begin
          e_ovr = 1;
        end
      end else if (m_valid && word_ready) begin
        m_valid = 0;
      end
      m_ovr = (m_ovr && !err_clr) || e_ovr;
      m_fe  = (m_fe && !err_clr) || e_fe;
      sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sclk_in;
      dh[2] = dh[1]; dh[1] = sdata_in;
      nh[2] = nh[1]; nh[1] = sel_n_in;
    end
  end

  always @(negedge clk) begin
    logic [W+3:0] act;
    logic [W+3:0] exp;
    if (m_init) begin
      act = {word_out, word_valid, busy, overrun, frame_err};
      exp = {m_out, m_valid, m_frame, m_ovr, m_fe};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got=%h exp=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_on) begin
        word_ready = 1'($urandom_range(0, 1));
        err_clr = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  // pm: 0 none, 1 pulse word_ready, 2 pulse err_clr, timed
  // to the clk edge where this bit completes a word.
  task automatic send_bit(input bit b, input int pm);
    sdata_in = b;
    cyc(4);
    sclk_in = 1'b1;
    cyc(2);
    if (pm == 1) word_ready = 1'b1;
    if (pm == 2) err_clr = 1'b1;
    cyc(1);
    if (pm == 1) word_ready = 1'b0;
    if (pm == 2) err_clr = 1'b0;
    cyc(1);
    sclk_in = 1'b0;
    cyc(3);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int nb,
                           input int pm);
    for (int i = 0; i < nb; i++)
      send_bit(w[i], (i == nb - 1) ? pm : 0);
  endtask

  task automatic open_frame();
    sel_n_in = 1'b0;
    cyc(4);
  endtask

  task automatic close_frame();
    cyc(3);
    sel_n_in = 1'b1;
    cyc(6);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1;
    sclk_in = 1'b0;
    sdata_in = 1'b0;
    sel_n_in = 1'b1;
    word_ready = 1'b0;
    err_clr = 1'b0;
    cyc(3);
    chk("reset_outs",
        {word_out, word_valid, busy, overrun, frame_err}, '0);
    reset = 1'b0;
    cyc(2);

    // 1: single word, always ready
    word_ready = 1'b1;
    open_frame();
    send_word(16'hA5C3, W, 0);
    close_frame();
    chk("t1_word", word_out, 16'hA5C3);
    chk("t1_model", m_out, 16'hA5C3);
    chk("t1_flags", {overrun, frame_err, word_valid}, 3'b000);

    // 2: three words, not ready
    word_ready = 1'b0;
    open_frame();
    send_word(16'h0001, W, 0);
    send_word(16'h8000, W, 0);
    send_word(16'hFFFF, W, 0);
    close_frame();
    chk("t2_word", word_out, 16'h0001);
    chk("t2_valid_ovr", {word_valid, overrun}, 2'b11);
    word_ready = 1'b1;
    cyc(1);
    word_ready = 1'b0;
    cyc(1);
    chk("t2_consumed", word_valid, 1'b0);

    // 3: truncated frame then a good one
    pulse_clr();
    open_frame();
    send_word(16'h007F, 7, 0);
    close_frame();
    chk("t3_fe", {frame_err, busy, word_valid}, 3'b100);
    word_ready = 1'b1;
    open_frame();
    send_word(16'h1234, W, 0);
    close_frame();
    chk("t3_word", word_out, 16'h1234);

    // 4: err_clr collides with a new overrun
    word_ready = 1'b0;
    pulse_clr();
    open_frame();
    send_word(16'h0A0A, W, 0);
    send_word(16'h0B0B, W, 0);
    chk("t4_ovr_set", overrun, 1'b1);
    send_word(16'h0C0C, W, 2);
    chk("t4_ovr_kept", overrun, 1'b1);
    pulse_clr();
    chk("t4_ovr_clr", overrun, 1'b0);
    close_frame();

    // 5: completion coincides with consume
    word_ready = 1'b1;
    cyc(1);
    word_ready = 1'b0;
    open_frame();
    send_word(16'h1111, W, 0);
    send_word(16'h2222, W, 1);
    chk("t5_word", word_out, 16'h2222);
    chk("t5_valid_ovr", {word_valid, overrun}, 2'b10);
    close_frame();

    // 6: reset mid-word, sel_n held low across it
    word_ready = 1'b1;
    open_frame();
    send_word(16'h01FF, 9, 0);
    reset = 1'b1;
    cyc(2);
    chk("t6_reset",
        {word_out, word_valid, busy, overrun, frame_err}, '0);
    reset = 1'b0;
    cyc(4);
    send_word(16'h00FF, W, 0);
    cyc(2);
    chk("t6_word", word_out, 16'h00FF);
    chk("t6_fe", frame_err, 1'b0);
    close_frame();

    // random frames
    rnd_on = 1'b1;
    for (int f = 0; f < 30; f++) begin
      sel_n_in = 1'b0;
      cyc($urandom_range(3, 8));
      for (int k = 0; k < $urandom_range(1, 3); k++)
        send_word(W'($urandom), W, 0);
      if ($urandom_range(0, 3) == 0)
        send_word(W'($urandom), $urandom_range(1, W - 1), 0);
      cyc($urandom_range(3, 6));
      sel_n_in = 1'b1;
      cyc($urandom_range(5, 12));
    end
    rnd_on = 1'b0;
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Serial word receiver controller for the host-to-MAC command path.
- Synchronises an external serial clock, data and active-low frame select into the `clk` domain. Sequences an internal LSB-first logical right-shift register and counts bits per word.
- Presents each completed WIDTH-bit word to downstream logic over a valid/ready handshake.
- Reports overrun and frame-truncation errors through sticky flags.

Parameters:
- WIDTH, 16, bits per word; legal range 2..64.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk_in  input  1  asynchronous serial bit clock from host; data is valid on its rising edge.
- sdata_in  input  1  asynchronous serial data, LSB first.
- sel_n_in  input  1  asynchronous frame select, active low.
- word_out  output  WIDTH  last completed word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream accepts word_out when it is high together with word_valid.
- busy  output  1  high while state is SHIFT.
- overrun  output  1  sticky: a word completed while the previous word was still unconsumed.
- frame_err  output  1  sticky: sel_n rose with a partial word pending.
- err_clr  input  1  clears overrun and frame_err.

Behaviour:
- Clock and reset: one clock (`clk`). `reset` is synchronous and active-high. While reset=1 at a clk edge:
  - word_out=0, word_valid=0, overrun=0, frame_err=0, busy=0.
  - State=IDLE, bit_cnt=0, shift register=0.
  - Sync chains load idle levels: sclk 0, sdata 0, sel_n 1.
- Synchronisers:
  - sclk, sdata and sel_n each pass through a 2-flop chain (s1, s2).
  - sclk has a third flop, s3.
  - rise = sclk_s2 & ~sclk_s3. The sampled bit is sdata_s2.
- Host timing requirement: sclk_in high and low each ≥ 3 clk periods. sdata_in stable ≥ 3 clk periods around the sclk_in rise. Violations are not detected.
- State machine (two states):
  - IDLE:
    - bit_cnt=0.
    - When sel_n_s2=0: go to SHIFT, clear the shift register.
    - A rise seen in IDLE is ignored.
  - SHIFT, on a rise:
    - sr <= {sdata_s2, sr[WIDTH-1:1]}.
    - If bit_cnt==WIDTH-1: word completes, bit_cnt <= 0, stay in SHIFT. Multiple words per frame are allowed.
    - Otherwise bit_cnt++.
  - SHIFT, when sel_n_s2=1:
    - Go to IDLE.
    - If bit_cnt≠0, set frame_err and discard the partial word.
    - If sel_n_s2=1 and a rise occur in the same cycle, the sel_n exit takes precedence and the bit is discarded.
- Word completion:
  - The completed value is the post-shift register value.
  - If word_valid=0, or word_valid=1 with word_ready=1 in that cycle: word_out <= completed word, word_valid <= 1.
  - Otherwise: set overrun, drop the new word, word_out keeps the old value.
- Latency: if the final sclk_in rise is first captured by sclk_s1 at clk edge k, word_valid=1 and word_out are updated after edge k+2.
- Handshake:
  - word_valid & word_ready with no completion in the same cycle: word_valid <= 0, word_out holds its value.
  - word_out is stable while word_valid=1.
- Error flags:
  - err_clr=1 clears both flags.
  - A new error event in the same cycle as err_clr wins: the flag stays 1.
  - Flags do not affect reception.
- Reset mid-frame or mid-word: everything returns to reset values. After reset the block waits in IDLE for sel_n_s2=0. If sel_n_in is still low, it re-enters SHIFT on the cycle sel_n_s2 first reads 0 and starts a fresh word.
- busy = (state==SHIFT), registered.

Test Plan:
1. Reset, then one frame with WIDTH=16 sending 0xA5C3 LSB first, word_ready=1 throughout → word_valid pulses for 1 cycle with word_out=0xA5C3, at k+2 after the last sclk capture; no error flags set.
2. One frame of three words 0x0001, 0x8000, 0xFFFF, word_ready=0 until after the third word → word_out=0x0001 and word_valid=1; overrun=1 after word 2; words 2 and 3 dropped. Then word_ready=1 for 1 cycle → word_valid=0.
3. Send 7 bits, then deassert sel_n_in → frame_err=1, state IDLE, word_valid stays 0. Next frame 0x1234 is received correctly.
4. overrun=1, then err_clr=1 in the same cycle as a new overrun event → overrun stays 1. err_clr alone on the next cycle → overrun=0.
5. word_valid=1 (0x1111); next word 0x2222 completes in the same cycle that word_ready=1 → word_out=0x2222, word_valid stays 1, overrun=0.
6. reset asserted after bit 9 of a word → all outputs 0. Continuous 16 sclk pulses after reset release with sel_n_in still low → receives a clean new word (e.g. 0x00FF) with no frame_err.
